// File: rtl/scope_if.sv
// Sample stream and display read port shared between the acquisition stage
// and its neighbours. The acquisition stage is the slave on both.
interface scope_if #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 8
);
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [ADDR_W-1:0]   rd_addr;
  logic [SAMPLE_W-1:0] rd_data;

  modport master (
    output sample_valid,
    output sample,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  sample_valid,
    input  sample,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/scope_capture.sv
// Trigger and acquisition stage for the oscilloscope display core.
// Waits for a level crossing (or an auto-mode timeout), decimates the
// post-trigger stream into a DEPTH-point frame buffer, then holds the frame
// until the display's vsync releases it.
module scope_capture #(
  parameter int SAMPLE_W     = 8,
  parameter int LEVEL_W      = 6,
  parameter int ADDR_W       = 8,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  scope_if.slave             bus,
  input  logic               slope,
  input  logic               mode,
  input  logic [LEVEL_W-1:0] level,
  input  logic [1:0]         time_per_div,
  input  logic               vsync_in,
  output logic               frame_ready,
  output logic               triggered,
  output logic [1:0]         state_out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ARMED   = 2'b00,
    CAPTURE = 2'b01,
    HOLD    = 2'b10
  } state_t;

  state_t state, next_state;

  // Trigger detection state
  logic [SAMPLE_W-1:0] prev;
  logic                prev_valid;
  logic [TO_W-1:0]     to_cnt;

  // Capture state
  logic [1:0]          dec_sel;
  logic [2:0]          dec_cnt;
  logic [ADDR_W-1:0]   wr_addr;
  logic                trig_flag;

  // vsync edge detector
  logic                vsync_d1, vsync_d2;

  // Frame buffer
  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Derived combinational signals
  logic [SAMPLE_W-1:0] thr;
  logic                crossing;
  logic                timeout;
  logic                vsync_edge;
  logic [2:0]          dec_mask;
  logic [2:0]          dec_next;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;

  // FSM decode outputs
  logic                trig_start;
  logic                trig_real;
  logic                cap_we;
  logic                cap_last;
  logic                release_frame;

  assign thr        = SAMPLE_W'(level) << (SAMPLE_W - LEVEL_W);
  assign crossing   = prev_valid &&
                      (slope ? (prev > thr && bus.sample <= thr)
                             : (prev < thr && bus.sample >= thr));
  assign timeout    = mode && (to_cnt == TO_LAST);
  assign vsync_edge = vsync_d1 & ~vsync_d2;
  // Counter is dec_sel bits wide: masking the increment makes it wrap at 2**dec_sel.
  assign dec_mask   = 3'((4'd1 << dec_sel) - 4'd1);
  assign dec_next   = (dec_cnt + 3'd1) & dec_mask;
  assign mem_we     = trig_start | cap_we;
  assign mem_waddr  = trig_start ? '0 : wr_addr;
  assign state_out  = state;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARMED;
    else     state <= next_state;
  end

  // Next-state and per-cycle control decode
  // NOTE: every output gets a default first, so no path leaves a signal unassigned (no latches).
  always_comb begin
    next_state    = state;
    trig_start    = 1'b0;
    trig_real     = 1'b0;
    cap_we        = 1'b0;
    cap_last      = 1'b0;
    release_frame = 1'b0;
    case (state)
      ARMED: begin
        // A crossing on the timeout sample wins, so trig_real follows crossing.
        if (bus.sample_valid && (crossing || timeout)) begin
          trig_start = 1'b1;
          trig_real  = crossing;
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.sample_valid && dec_next == 3'd0) begin
          cap_we = 1'b1;
          if (wr_addr == '1) begin
            cap_last   = 1'b1;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        // Only edges seen while already holding release the frame.
        if (vsync_edge) begin
          release_frame = 1'b1;
          next_state    = ARMED;
        end
      end
      default: next_state = ARMED;
    endcase
  end

  // Trigger history, decimation, write pointer and frame status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev        <= '0;
      prev_valid  <= 1'b0;
      to_cnt      <= '0;
      dec_sel     <= 2'd0;
      dec_cnt     <= 3'd0;
      wr_addr     <= '0;
      trig_flag   <= 1'b0;
      frame_ready <= 1'b0;
      triggered   <= 1'b0;
      vsync_d1    <= 1'b0;
      vsync_d2    <= 1'b0;
    end else begin
      vsync_d1 <= vsync_in;
      vsync_d2 <= vsync_d1;

      if (state == ARMED && bus.sample_valid) begin
        prev       <= bus.sample;
        prev_valid <= 1'b1;
        if (!trig_start && mode) to_cnt <= to_cnt + TO_W'(1);
      end

      if (trig_start) begin
        dec_sel   <= time_per_div;
        dec_cnt   <= 3'd0;
        wr_addr   <= ADDR_W'(1);
        trig_flag <= trig_real;
      end

      if (state == CAPTURE && bus.sample_valid) dec_cnt <= dec_next;
      if (cap_we) wr_addr <= wr_addr + ADDR_W'(1);

      if (cap_last) begin
        frame_ready <= 1'b1;
        triggered   <= trig_flag;
      end

      // Re-arming: the next valid sample only seeds prev and cannot trigger.
      if (release_frame) begin
        frame_ready <= 1'b0;
        prev_valid  <= 1'b0;
        to_cnt      <= '0;
      end
    end
  end

  // Frame buffer write port
  // NOTE: the buffer RAM has no reset; frame_ready tells the reader when its contents are valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bus.sample;
  end

  // Synchronous display read port, active in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.rd_data <= '0;
    else     bus.rd_data <= mem[bus.rd_addr];
  end

endmodule
